alu_execute_stage: RTL and testbench
====================================

Name: alu_execute_stage

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code plus two operands; produces a registered result and NZCV-style flags.
- Uses a valid/ready handshake toward the register-writeback/branch logic.
- Single-cycle ops have latency 1 at full throughput; an optional iterative multiplier adds a multi-cycle path.

Parameters:
- WIDTH, 64, operand/result width in bits.
- TAG_W, 5, width of the pass-through destination-register tag.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage can accept an operation this cycle.
- alu_op  in  4  operation code from ALU control.
- op_a  in  WIDTH  first operand (Rn).
- op_b  in  WIDTH  second operand (Rm / immediate).
- in_tag  in  TAG_W  destination register index, passed through unchanged.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  carry / not-borrow.
- flag_v  out  1  signed overflow.
- out_tag  out  TAG_W  tag of the held result.
- illegal_op  out  1  held result came from an unsupported alu_op.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid, result, all flags, out_tag and illegal_op go to 0.
  - FSM goes to IDLE.
  - in_ready is 1 in the first cycle after release.
- Accept: an operation is taken when in_valid && in_ready on a rising clk edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational from out_ready and state only, never from in_valid.
- Single-cycle ops: result, flags, tag and out_valid=1 are registered on the accept edge (latency 1).
- Hold: while out_valid && !out_ready, all outputs stay stable.
- Same-edge accept and drain (out_ready && in_valid && in_ready): the new result replaces the old one and out_valid stays 1, giving one operation per cycle.
- Drain with no accept: out_ready && out_valid && !accept clears out_valid. result and flags keep their last value.
- Operation codes:
  - 0010 ADD: a+b. C = carry out of bit WIDTH-1. V = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - 0110 SUB: a+~b+1. C = 1 when no borrow (a>=b unsigned). V = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - 0000 AND: a&b, C=V=0.
  - 0001 ORR: a|b, C=V=0.
  - 0111 PASS_B: r=b (CBZ test), C=V=0.
  - Any other code: r=0, Z=N=C=V=0, illegal_op=1. The handshake still completes normally.
- Z and N are always derived from r, except for illegal ops (both forced 0).
- Arithmetic is WIDTH bits, wraps modulo 2^WIDTH, and uses no saturation.
- FSM states:
  - IDLE: single-cycle ops accepted here.
  - MUL: entered only with ALU_MUL_EN.
  - Without the macro the FSM never leaves IDLE.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined:
  - alu_op 1000 = MUL, low WIDTH bits of a*b.
  - On accept the FSM goes IDLE->MUL and the sub-module runs one shift-add step per cycle for WIDTH cycles.
  - in_ready=0 throughout MUL.
  - On completion the result is registered with out_valid=1 and the FSM returns to IDLE. Latency is WIDTH+1 cycles from accept.
  - Flags: Z and N from the product, C=V=0.
  - The FSM does not leave MUL early even if out_ready toggles.
  - A MUL is accepted only when the result register is free or draining that cycle.
  - Reset mid-MUL aborts the operation; no out_valid is produced for it.
- Undefined: 1000 is treated as an illegal op (latency 1, illegal_op=1).

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams: ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_ORR=4'b0001, ALU_PASSB=4'b0111, ALU_MUL=4'b1000.
  - The FSM state encoding.
  - A flags typedef {z,n,c,v}.
- Sub-module alu_mul_seq: iterative shift-add multiplier with start/busy/done ports, instantiated only under ALU_MUL_EN.

Test Plan:
- Reset release, then ADD a=5, b=7, out_ready=1: one cycle later out_valid=1, result=12, Z=N=C=V=0, in_ready stays 1.
- SUB a=3, b=3: result=0, Z=1, C=1. Then SUB a=0, b=1: result=all ones, N=1, C=0.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1: result=0x8000_0000_0000_0000, N=1, V=1, C=0. ADD all-ones + 1: result=0, Z=1, C=1.
- Back-pressure: out_ready=0 while issuing AND(0xF0,0x3C), then ORR: in_ready=0, result holds 0x30 stable. Raise out_ready: 0x30 drains, then ORR result 0xFC appears next cycle.
- alu_op=4'b1111, a=9, b=9: out_valid=1, result=0, illegal_op=1, all flags 0. The next valid op clears illegal_op.
- Under ALU_MUL_EN: MUL a=6, b=7 gives in_ready=0 for 64 cycles, then result=42 with out_valid at cycle 65. Assert rst_n=0 at cycle 30 of a second MUL: no result is produced and outputs read 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the execute-stage ALU.
// The MUL opcode is only honoured when the design is built with ALU_MUL_EN.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } aluState_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } aluFlags_t;

endpackage

// File: rtl/alu_execute_stage_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps, low WIDTH bits kept.
// Instantiated by alu_execute_stage only when ALU_MUL_EN is defined.
module alu_mul_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] remaining;

    // The first step is folded into the start edge, so WIDTH steps finish WIDTH-1 edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            remaining <= '0;
            busy      <= 1'b0;
        end else if (start) begin
            acc       <= b[0] ? a : '0;
            mcand     <= a << 1;
            mplier    <= b >> 1;
            remaining <= CNT_W'(WIDTH - 1);
            busy      <= 1'b1;
        end else if (busy) begin
            if (remaining == '0) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand     <= mcand << 1;
                mplier    <= mplier >> 1;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    assign done    = busy && (remaining == '0);
    assign product = acc;

endmodule

// File: rtl/alu_execute_stage.sv
// Execute-stage ALU with registered result/NZCV flags and a valid/ready output handshake.
// Define ALU_MUL_EN to add the iterative multiplier (opcode 1000); otherwise 1000 is illegal.
module alu_execute_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal_op
);

    localparam int MSB = WIDTH - 1;

    aluState_t        state;
    aluFlags_t        flags;
    logic             accept;
    logic             isMulOp;
    logic [WIDTH-1:0] aluRes;
    aluFlags_t        aluFlags;
    logic             aluIllegal;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             mulBusy;
    logic             mulDone;
    logic [WIDTH-1:0] mulProduct;
    logic [TAG_W-1:0] mulTag;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        aluRes     = '0;
        aluFlags   = '0;
        aluIllegal = 1'b0;
        sum        = {1'b0, op_a} + {1'b0, op_b};
        diff       = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
        case (alu_op)
            ALU_ADD: begin
                aluRes     = sum[MSB:0];
                aluFlags.c = sum[WIDTH];
                aluFlags.v = (op_a[MSB] == op_b[MSB]) && (aluRes[MSB] != op_a[MSB]);
            end
            ALU_SUB: begin
                aluRes     = diff[MSB:0];
                aluFlags.c = diff[WIDTH];
                aluFlags.v = (op_a[MSB] != op_b[MSB]) && (aluRes[MSB] != op_a[MSB]);
            end
            ALU_AND:   aluRes = op_a & op_b;
            ALU_ORR:   aluRes = op_a | op_b;
            ALU_PASSB: aluRes = op_b;
            default:   aluIllegal = 1'b1;
        endcase
        // Illegal ops report an all-zero flag set, so Z is not derived from the zero result.
        if (!aluIllegal) begin
            aluFlags.z = (aluRes == '0);
            aluFlags.n = aluRes[MSB];
        end
    end

`ifdef ALU_MUL_EN
    assign isMulOp = (alu_op == ALU_MUL);

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) uMulSeq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && isMulOp),
        .a       (op_a),
        .b       (op_b),
        .busy    (mulBusy),
        .done    (mulDone),
        .product (mulProduct)
    );
`else
    assign isMulOp    = 1'b0;
    assign mulBusy    = 1'b0;
    assign mulDone    = 1'b0;
    assign mulProduct = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            result     <= '0;
            flags      <= '0;
            out_tag    <= '0;
            illegal_op <= 1'b0;
            mulTag     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && isMulOp) begin
                        // Accept implies the result register was empty or drains on this edge.
                        state     <= MUL;
                        mulTag    <= in_tag;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_valid  <= 1'b1;
                        result     <= aluRes;
                        flags      <= aluFlags;
                        out_tag    <= in_tag;
                        illegal_op <= aluIllegal;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (mulDone) begin
                        state      <= IDLE;
                        out_valid  <= 1'b1;
                        result     <= mulProduct;
                        flags      <= '{z: (mulProduct == '0), n: mulProduct[MSB], c: 1'b0, v: 1'b0};
                        out_tag    <= mulTag;
                        illegal_op <= 1'b0;
                    end else if (!mulBusy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign flag_z = flags.z;
    assign flag_n = flags.n;
    assign flag_c = flags.c;
    assign flag_v = flags.v;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Self-checking bench for alu_execute_stage: directed corner cases plus random ops against a scoreboard.
// Build with ALU_MUL_EN defined to also exercise the multi-cycle multiplier.
module tb_alu_execute_stage;

    localparam int W  = 64;
    localparam int TW = 5;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    localparam logic signed [W+1:0] MAXS = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MINS = ~MAXS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_op;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          flag_z, flag_n, flag_c, flag_v;
    logic [TW-1:0] out_tag;
    logic          illegal_op;

    typedef struct {
        logic [W-1:0]  r;
        logic [3:0]    znvc;
        logic [TW-1:0] tag;
        logic          ill;
    } expected_t;

    expected_t sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_execute_stage #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .out_tag    (out_tag),
        .illegal_op (illegal_op)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: flags from the arithmetic definitions (true signed sum range, unsigned compare).
    function automatic expected_t model(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [TW-1:0] tag);
        expected_t e;
        logic signed [W+1:0] sa, sbv, s;
        logic c, v;
        sa  = $signed({{2{a[W-1]}}, a});
        sbv = $signed({{2{b[W-1]}}, b});
        c = 1'b0;
        v = 1'b0;
        e.ill = 1'b0;
        e.tag = tag;
        e.r   = '0;
        case (op)
            OP_ADD: begin
                e.r = a + b;
                c   = (e.r < a);
                s   = sa + sbv;
                v   = (s > MAXS) || (s < MINS);
            end
            OP_SUB: begin
                e.r = a - b;
                c   = (a >= b);
                s   = sa - sbv;
                v   = (s > MAXS) || (s < MINS);
            end
            OP_AND:   e.r = a & b;
            OP_ORR:   e.r = a | b;
            OP_PASSB: e.r = b;
`ifdef ALU_MUL_EN
            OP_MUL:   e.r = a * b;
`endif
            default:  e.ill = 1'b1;
        endcase
        if (e.ill) e.znvc = 4'b0000;
        else       e.znvc = {e.r == 0, e.r[W-1], c, v};
        return e;
    endfunction

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            4:       return 1;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Present an op and hold it until accepted; the expectation is queued just before the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input bit randRdy);
        int waited = 0;
        bit ok = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_tag   = tag;
        forever begin
            if (randRdy) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout: in_ready stayed %b for op %b", in_ready, op);
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            sb.push_back(model(op, a, b, tag));
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic expectNext(input string name, input logic [W-1:0] r, input logic [3:0] znvc,
                              input logic ill);
        @(negedge clk);
        #1;
        check(name, {out_valid, result, flag_z, flag_n, flag_c, flag_v, illegal_op},
              {1'b1, r, znvc, ill});
    endtask

    // Monitor: whenever a result is presented it must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: out_valid=%b with empty scoreboard, result=%h",
                             out_valid, result);
                end else begin
                    check("monitor",
                          {result, flag_z, flag_n, flag_c, flag_v, out_tag, illegal_op},
                          {sb[0].r, sb[0].znvc, sb[0].tag, sb[0].ill});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int busyCycles;
        int strayValid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = '0;
        op_a      = '0;
        op_b      = '0;
        in_tag    = '0;
        #12;
        check("reset_outputs", {out_valid, result, flag_z, flag_n, flag_c, flag_v, out_tag, illegal_op}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1'b1);

        issue(OP_ADD, 5, 7, 5'd1, 1'b0);
        expectNext("add_5_7", 12, 4'b0000, 1'b0);
        check("add_in_ready", in_ready, 1'b1);

        issue(OP_SUB, 3, 3, 5'd2, 1'b0);
        expectNext("sub_equal", 0, 4'b1010, 1'b0);
        issue(OP_SUB, 0, 1, 5'd3, 1'b0);
        expectNext("sub_borrow", '1, 4'b0100, 1'b0);
        issue(OP_ADD, {1'b0, {(W-1){1'b1}}}, 1, 5'd4, 1'b0);
        expectNext("add_overflow", {1'b1, {(W-1){1'b0}}}, 4'b0101, 1'b0);
        issue(OP_ADD, '1, 1, 5'd5, 1'b0);
        expectNext("add_carry", 0, 4'b1010, 1'b0);

        // Back-pressure: AND result held while ORR waits, then drain and accept on the same edge.
        issue(OP_AND, 64'hF0, 64'h3C, 5'd6, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = OP_ORR;
        op_a     = 64'hF0;
        op_b     = 64'h3C;
        in_tag   = 5'd7;
        #1;
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_hold_1", {out_valid, result}, {1'b1, 64'h30});
        repeat (2) @(negedge clk);
        #1;
        check("bp_in_ready_still_low", in_ready, 1'b0);
        check("bp_hold_2", {out_valid, result}, {1'b1, 64'h30});
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", in_ready, 1'b1);
        sb.push_back(model(OP_ORR, 64'hF0, 64'h3C, 5'd7));
        @(posedge clk);
        #1 in_valid = 1'b0;
        expectNext("bp_orr", 64'hFC, 4'b0000, 1'b0);

        issue(4'b1111, 9, 9, 5'd8, 1'b0);
        expectNext("illegal_1111", 0, 4'b0000, 1'b1);
        issue(OP_PASSB, 9, 0, 5'd9, 1'b0);
        expectNext("illegal_cleared", 0, 4'b1000, 1'b0);

`ifdef ALU_MUL_EN
        issue(OP_MUL, 6, 7, 5'd10, 1'b0);
        busyCycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) break;
            if (!in_ready) busyCycles++;
        end
        check("mul_busy_cycles", busyCycles, W);
        check("mul_result", {out_valid, result, flag_z, flag_n, flag_c, flag_v, illegal_op},
              {1'b1, 64'd42, 4'b0000, 1'b0});

        issue(OP_MUL, 64'd123456789, 64'd987654321, 5'd11, 1'b0);
        repeat (29) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mul_reset_outputs", {out_valid, result, flag_z, flag_n, flag_c, flag_v, out_tag, illegal_op}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        strayValid = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) strayValid++;
        end
        check("mul_reset_no_result", strayValid, 0);
        check("mul_reset_in_ready", in_ready, 1'b1);
`else
        issue(OP_MUL, 6, 7, 5'd10, 1'b0);
        expectNext("mul_disabled_illegal", 0, 4'b0000, 1'b1);
`endif

        // Random traffic with random back-pressure; the monitor checks every presented result.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            case ($urandom_range(0, 7))
                0:       op = OP_ADD;
                1:       op = OP_SUB;
                2:       op = OP_AND;
                3:       op = OP_ORR;
                4:       op = OP_PASSB;
                5:       op = ($urandom_range(0, 9) == 0) ? OP_MUL : OP_ADD;
                6:       op = 4'($urandom_range(0, 15));
                default: op = OP_SUB;
            endcase
            issue(op, randOperand(), randOperand(), TW'($urandom_range(0, 31)), 1'b1);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end

        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
